cpu_display_scan: RTL and testbench



---
 rtl/disp_pkg.sv | 20 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/cpu_display_scan.sv | 136 +++++++++++++
 tb/tb_cpu_display_scan.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the seven-segment scan driver
package disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low seven-segment decode
module hex_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/cpu_display_scan.sv
// rtl/cpu_display_scan.sv - four-digit multiplexed display of pc/prog/acc with frame-aligned snapshots
// Optional DISP_HEARTBEAT_EN: dp on digit 0 shows a heartbeat that toggles per snapshot load.
module cpu_display_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_tick,
    input  logic [3:0] pc,
    input  logic [7:0] prog,
    input  logic [3:0] acc,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    import disp_pkg::*;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    scan_state_t      state, stateNext;
    digit_idx_t       digitIdx, digitNext;
    logic [CNT_W-1:0] slotCnt, cntNext;
    logic [6:0]       segNext, decSeg;
    logic [3:0]       anNext, curNibble;
    logic             frameEnd;

    // Word layout {pc, prog, acc} puts digit d at bits [4d+3:4d]
    logic [15:0] stageReg, dispReg, liveWord;
    logic        pending;

    assign liveWord  = {pc, prog, acc};
    assign curNibble = dispReg[{digitIdx, 2'b00} +: 4];

    hex_to_seg7 uDec (
        .nibble(curNibble),
        .seg   (decSeg)
    );

    always_comb begin
        stateNext = state;
        digitNext = digitIdx;
        cntNext   = slotCnt + 1'b1;
        segNext   = SEG_BLANK;
        anNext    = AN_OFF;
        frameEnd  = 1'b0;
        case (state)
            BLANK: begin
                if (slotCnt == BLANK_LAST) begin
                    stateNext = DRIVE;
                end
            end
            DRIVE: begin
                if (slotCnt == SLOT_LAST) begin
                    stateNext = BLANK;
                    digitNext = digitIdx - 2'd1;
                    cntNext   = '0;
                    frameEnd  = (digitIdx == 2'd0);
                end
            end
        endcase
        if (stateNext == DRIVE) begin
            anNext  = ~(4'b0001 << digitNext);
            segNext = decSeg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BLANK;
            digitIdx <= 2'd3;
            slotCnt  <= '0;
            seg      <= SEG_BLANK;
            an       <= AN_OFF;
        end else begin
            state    <= stateNext;
            digitIdx <= digitNext;
            slotCnt  <= cntNext;
            seg      <= segNext;
            an       <= anNext;
        end
    end

    // A tick on the boundary cycle bypasses the stage so latency can be one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stageReg <= '0;
            dispReg  <= '0;
            pending  <= 1'b0;
        end else begin
            if (cpu_tick) begin
                stageReg <= liveWord;
            end
            if (frameEnd) begin
                if (cpu_tick) begin
                    dispReg <= liveWord;
                end else if (pending) begin
                    dispReg <= stageReg;
                end
                pending <= 1'b0;
            end else if (cpu_tick) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef DISP_HEARTBEAT_EN
    logic heartbeat;
    logic dpNext;

    always_comb begin
        dpNext = 1'b1;
        if (stateNext == DRIVE && digitNext == 2'd0) begin
            dpNext = ~heartbeat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            heartbeat <= 1'b0;
            dp        <= 1'b1;
        end else begin
            if (frameEnd && (cpu_tick || pending)) begin
                heartbeat <= ~heartbeat;
            end
            dp <= dpNext;
        end
    end
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_cpu_display_scan.sv
// tb/tb_cpu_display_scan.sv - scoreboard bench for cpu_display_scan with REFRESH_DIV=8, BLANK_CYCLES=2
module tb_cpu_display_scan;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_tick = 1'b0;
    logic [3:0] pc = '0;
    logic [7:0] prog = '0;
    logic [3:0] acc = '0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int total = 0;
    int bad = 0;

    exp_t q[$];
    logic [6:0] segTab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [15:0] dispM, stageM, live;
    logic        pendM, hbM, tickNow, bndTick;

    cpu_display_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .cpu_tick(cpu_tick), .pc(pc), .prog(prog),
        .acc(acc), .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    task automatic pushFrame();
        exp_t e;
        for (int d = 3; d >= 0; d--) begin
            e.an  = ~(4'b0001 << d);
            e.seg = segTab[dispM[d*4 +: 4]];
            e.dp  = 1'b1;
`ifdef DISP_HEARTBEAT_EN
            if (d == 0) e.dp = ~hbM;
`endif
            q.push_back(e);
        end
    endtask

    // Monitor: checks blanking, slot lengths, one-hot anodes and pops expected digits
    logic [3:0] prevAn = 4'hF;
    int blankLen = 0;
    int driveLen = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prevAn   = 4'hF;
            blankLen = 0;
            driveLen = 0;
        end else begin
            if (an == 4'hF) begin
                if (prevAn != 4'hF) begin
                    chk("drive_len", driveLen, 6);
                    driveLen = 0;
                end
                blankLen++;
                chk("blank_seg", seg, 7'h7F);
                chk("blank_dp", dp, 1'b1);
            end else begin
                chk("one_anode", $countones(~an), 1);
                if (prevAn == 4'hF) begin
                    chk("blank_len", blankLen, 2);
                    blankLen = 0;
                    if (q.size() == 0) begin
                        chk("sb_unexpected_digit", an, 4'hF);
                    end else begin
                        e = q.pop_front();
                        chk("sb_an", an, e.an);
                        chk("sb_seg", seg, e.seg);
                        chk("sb_dp", dp, e.dp);
                    end
                end
                driveLen++;
            end
            prevAn = an;
        end
    end

    initial begin
        dispM = '0; stageM = '0; pendM = 1'b0; hbM = 1'b0;
        @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_pending", dut.pending, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int f = 0; f < 7; f++) begin
            pushFrame();
            if (f == 5) chk("pend_after_bnd_tick", dut.pending, 1'b0);
            bndTick = 1'b0;
            for (int c = 0; c < 32; c++) begin
                tickNow = 1'b0;
                live = 16'($urandom);
                if (f == 2 && c == 10) begin tickNow = 1'b1; live = 16'h3A5F; end
                if (f == 3 && c == 5)  begin tickNow = 1'b1; live = 16'h3A51; end
                if (f == 3 && c == 20) begin tickNow = 1'b1; live = 16'h3A57; end
                if (f == 4 && c == 31) begin tickNow = 1'b1; live = 16'h3A59; end
                if (f == 6 && c == 19) begin
                    rst = 1'b1;
                    break;
                end
                {pc, prog, acc} = live;
                cpu_tick = tickNow;
                if (tickNow) begin
                    stageM = live;
                    if (c == 31) bndTick = 1'b1;
                    else pendM = 1'b1;
                end
                tickClk();
                cpu_tick = 1'b0;
                if (f == 2 && c == 10) chk("pend_set", dut.pending, 1'b1);
            end
            if (rst) break;
            if (bndTick) begin
                dispM = stageM; pendM = 1'b0; hbM = ~hbM;
            end else if (pendM) begin
                dispM = stageM; pendM = 1'b0; hbM = ~hbM;
            end
        end

        // Reset asserted during digit-1 DRIVE must blank at once
        @(negedge clk);
        chk("midrst_an", an, 4'hF);
        chk("midrst_seg", seg, 7'h7F);
        chk("midrst_dp", dp, 1'b1);
        q.delete();
        dispM = '0; stageM = '0; pendM = 1'b0; hbM = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pushFrame();
        for (int c = 0; c < 32; c++) begin
            {pc, prog, acc} = 16'($urandom);
            tickClk();
        end
        chk("sb_drain", q.size(), 0);
        chk("end_pending", dut.pending, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
